// File: rtl/text_term_pkg.sv
// Shared types and constants for the character-cell text terminal.
package text_term_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR_ALL = 2'd1,
    ST_CLEAR_ROW = 2'd2
  } term_state_e;

  localparam int unsigned CC_BS = 'h08;
  localparam int unsigned CC_LF = 'h0A;
  localparam int unsigned CC_FF = 'h0C;
  localparam int unsigned CC_CR = 'h0D;

  localparam int unsigned PRINT_FIRST = 'h20;
  localparam int unsigned PRINT_LAST  = 'h7E;

  // Zero-extended to the cell width this gives {attr 0, char space}.
  localparam int unsigned BLANK_CELL = 'h020;

endpackage

// File: rtl/text_char_ram.sv
// Screen cell storage: one write port, one registered read-first read port.
module text_char_ram #(
  parameter int DEPTH = 2400,
  parameter int DW    = 11,
  parameter logic [DW-1:0] BLANK = '0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          rd_blank_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; the array itself is never reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rd_blank_i ? BLANK : mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_terminal_buffer.sv
// Scrolling text terminal: stream interpreter, direct cell writes and a
// renderer read port over a circular row buffer.
module text_terminal_buffer
  import text_term_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int CHAR_W = 7,
  parameter int ATTR_W = 4,
  localparam int XW    = $clog2(COLS),
  localparam int YW    = $clog2(ROWS),
  localparam int DW    = CHAR_W + ATTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic [ATTR_W-1:0] in_attr,
  input  logic              wr_en,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [DW-1:0]     wr_data,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  output logic [DW-1:0]     rd_data,
  output logic [XW-1:0]     cursor_x,
  output logic [YW-1:0]     cursor_y,
  output logic              busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam logic [XW-1:0] X_LAST    = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(ROWS - 1);
  localparam logic [DW-1:0] BLANK     = DW'(BLANK_CELL);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0] ROW_SPAN  = AW'(COLS - 1);

  function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] top,
                                             input logic [YW-1:0] y);
    logic [YW:0] sum;
    sum = {1'b0, top} + {1'b0, y};
    if (sum > {1'b0, Y_LAST}) sum = sum - (YW+1)'(ROWS);
    return sum[YW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] row,
                                              input logic [XW-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  term_state_e   state_q;
  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;
  logic [YW-1:0] top_q, top_d;
  logic [AW-1:0] clr_addr_q, clr_end_q;
  logic          stream_acc, printable, line_adv, do_scroll, do_clear_all;
  logic          wr_in_range, rd_in_range;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata;

  assign busy        = (state_q != ST_IDLE);
  assign in_ready    = (state_q == ST_IDLE) && !wr_en;
  assign cursor_x    = cur_x_q;
  assign cursor_y    = cur_y_q;
  assign stream_acc  = in_valid && in_ready;
  assign printable   = (in_char >= CHAR_W'(PRINT_FIRST)) && (in_char <= CHAR_W'(PRINT_LAST));
  assign wr_in_range = (wr_x <= X_LAST) && (wr_y <= Y_LAST);
  assign rd_in_range = (rd_x <= X_LAST) && (rd_y <= Y_LAST);
  assign ram_raddr   = rd_in_range ? cell_addr(phys_row(top_q, rd_y), rd_x) : '0;

  always_comb begin
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    top_d        = top_q;
    line_adv     = 1'b0;
    do_scroll    = 1'b0;
    do_clear_all = 1'b0;
    if (stream_acc) begin
      if (printable) begin
        if (cur_x_q == X_LAST) begin
          cur_x_d  = '0;
          line_adv = 1'b1;
        end else begin
          cur_x_d = cur_x_q + XW'(1);
        end
      end else if (in_char == CHAR_W'(CC_LF)) begin
        cur_x_d  = '0;
        line_adv = 1'b1;
      end else if (in_char == CHAR_W'(CC_CR)) begin
        cur_x_d = '0;
      end else if (in_char == CHAR_W'(CC_BS)) begin
        cur_x_d = (cur_x_q == '0) ? '0 : cur_x_q - XW'(1);
      end else if (in_char == CHAR_W'(CC_FF)) begin
        cur_x_d      = '0;
        cur_y_d      = '0;
        top_d        = '0;
        do_clear_all = 1'b1;
      end
    end
    // Advancing past the bottom row rotates the buffer instead of moving the cursor.
    if (line_adv) begin
      if (cur_y_q == Y_LAST) begin
        do_scroll = 1'b1;
        top_d     = (top_q == Y_LAST) ? '0 : top_q + YW'(1);
      end else begin
        cur_y_d = cur_y_q + YW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CLEAR_ALL;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      top_q      <= '0;
      clr_addr_q <= '0;
      clr_end_q  <= LAST_CELL;
    end else begin
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      top_q   <= top_d;
      case (state_q)
        ST_IDLE: begin
          if (do_clear_all) begin
            state_q    <= ST_CLEAR_ALL;
            clr_addr_q <= '0;
            clr_end_q  <= LAST_CELL;
          end else if (do_scroll) begin
            // The old top physical row becomes the new bottom logical row.
            state_q    <= ST_CLEAR_ROW;
            clr_addr_q <= cell_addr(top_q, '0);
            clr_end_q  <= cell_addr(top_q, '0) + ROW_SPAN;
          end
        end
        default: begin
          clr_addr_q <= clr_addr_q + AW'(1);
          if (clr_addr_q == clr_end_q) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr_q;
    ram_wdata = BLANK;
    if (state_q != ST_IDLE) begin
      ram_we = 1'b1;
    end else if (wr_en) begin
      ram_we    = wr_in_range;
      ram_waddr = cell_addr(phys_row(top_q, wr_y), wr_x);
      ram_wdata = wr_data;
    end else if (stream_acc && printable) begin
      ram_we    = 1'b1;
      ram_waddr = cell_addr(phys_row(top_q, cur_y_q), cur_x_q);
      ram_wdata = {in_attr, in_char};
    end
  end

  text_char_ram #(
    .DEPTH (CELLS),
    .DW    (DW),
    .BLANK (BLANK)
  ) u_ram (
    .clk_i      (clk),
    .rst_ni     (reset),
    .we_i       (ram_we),
    .waddr_i    (ram_waddr),
    .wdata_i    (ram_wdata),
    .raddr_i    (ram_raddr),
    .rd_blank_i (!rd_in_range),
    .rdata_o    (rd_data)
  );

endmodule

// File: tb/tb_text_terminal_buffer.sv
// Directed bench with a logical-screen model compared against the DUT every cycle.
module tb_text_terminal_buffer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [10:0] BLANK = 11'h020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        wr_en = 1'b0;
  logic [6:0]  in_char = '0;
  logic [3:0]  in_attr = '0;
  logic [6:0]  wr_x = '0;
  logic [4:0]  wr_y = '0;
  logic [10:0] wr_data = '0;
  logic [6:0]  rd_x = '0;
  logic [4:0]  rd_y = '0;
  logic        in_ready, busy;
  logic [10:0] rd_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  int   vectors = 0;
  int   miscompares = 0;
  logic checking = 1'b0;

  // Model: screen held in logical row order; scrolling shifts rows up.
  logic [10:0] scr [ROWS][COLS];
  int          m_cx, m_cy, m_busy;
  logic        rd_known;
  logic [10:0] exp_rd;

  text_terminal_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .in_attr  (in_attr),
    .wr_en    (wr_en),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_data  (wr_data),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_data  (rd_data),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
    m_cx = 0; m_cy = 0; m_busy = CELLS;
    rd_known = 1'b1; exp_rd = '0;
  endtask

  task automatic m_newline();
    if (m_cy == ROWS - 1) begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = BLANK;
      m_busy = COLS;
    end else begin
      m_cy++;
    end
  endtask

  task automatic m_char(input logic [6:0] c, input logic [3:0] a);
    if (c >= 7'h20 && c <= 7'h7E) begin
      scr[m_cy][m_cx] = {a, c};
      if (m_cx == COLS - 1) begin m_cx = 0; m_newline(); end
      else m_cx++;
    end else begin
      case (c)
        7'h0A: begin m_cx = 0; m_newline(); end
        7'h0D: m_cx = 0;
        7'h08: if (m_cx > 0) m_cx--;
        7'h0C: begin
          for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) scr[r][k] = BLANK;
          m_cx = 0; m_cy = 0; m_busy = CELLS;
        end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_reset();
    end else if (m_busy > 0) begin
      rd_known = 1'b0;
      m_busy--;
    end else begin
      rd_known = 1'b1;
      exp_rd = (rd_x < COLS && rd_y < ROWS) ? scr[rd_y][rd_x] : BLANK;
      if (wr_en) begin
        if (wr_x < COLS && wr_y < ROWS) scr[wr_y][wr_x] = wr_data;
      end else if (in_valid) begin
        m_char(in_char, in_attr);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("busy", busy, m_busy > 0);
      check("in_ready", in_ready, (m_busy == 0) && !wr_en && reset);
      check("cursor_x", cursor_x, m_cx);
      check("cursor_y", cursor_y, m_cy);
      if (rd_known) check("rd_data", rd_data, exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin tick(); n++; end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  task automatic measure_busy(input string name, input int exp);
    int n = 0;
    while (busy && n < 5000) begin tick(); n++; end
    check(name, n, exp);
  endtask

  task automatic send_char(input logic [6:0] c, input logic [3:0] a);
    wait_idle();
    in_valid = 1'b1; in_char = c; in_attr = a;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic direct_wr(input logic [6:0] x, input logic [4:0] y, input logic [10:0] d);
    wait_idle();
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_cell(input logic [6:0] x, input logic [4:0] y,
                           input logic [10:0] exp, input string name);
    rd_x = x; rd_y = y;
    tick();
    check(name, rd_data, exp);
  endtask

  task automatic check_cursor(input int x, input int y, input string name);
    check(name, {cursor_y, cursor_x}, {y[4:0], x[6:0]});
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 checking = 1'b1;
    check("rst_rd_data", rd_data, 0);
    check("rst_in_ready", in_ready, 0);
    check_cursor(0, 0, "rst_cursor");
    tick(); tick();
    reset = 1'b1;
    measure_busy("boot_busy_cycles", 2400);
    check("boot_in_ready", in_ready, 1);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) read_cell(7'(x), 5'(y), BLANK, "boot_cell");
    read_cell(7'd80, 5'd0, BLANK, "oor_x_read");
    read_cell(7'd0, 5'd30, BLANK, "oor_y_read");

    send_char(7'h49, 4'h3); send_char(7'h20, 4'h3);
    send_char(7'h41, 4'h3); send_char(7'h4D, 4'h3);
    check_cursor(4, 0, "iam_cursor");
    read_cell(7'd0, 5'd0, 11'h1C9, "iam_I");
    read_cell(7'd1, 5'd0, 11'h1A0, "iam_sp");
    read_cell(7'd2, 5'd0, 11'h1C1, "iam_A");
    read_cell(7'd3, 5'd0, 11'h1CD, "iam_M");

    send_char(7'h08, 4'h0); check_cursor(3, 0, "bs_cursor");
    send_char(7'h0D, 4'h0); check_cursor(0, 0, "cr_cursor");
    send_char(7'h08, 4'h0); check_cursor(0, 0, "bs_saturate");
    send_char(7'h01, 4'h0); check_cursor(0, 0, "ignored_code");
    read_cell(7'd0, 5'd0, 11'h1C9, "bs_no_erase");
    send_char(7'h0A, 4'h0); check_cursor(0, 1, "lf_cursor");

    wait_idle();
    wr_en = 1'b1; wr_x = 7'd10; wr_y = 5'd2; wr_data = 11'h2DA;
    in_valid = 1'b1; in_char = 7'h51; in_attr = 4'h1;
    #1 check("collide_in_ready", in_ready, 0);
    tick();
    wr_en = 1'b0;
    #1 check("after_wr_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_cursor(1, 1, "collide_cursor");
    read_cell(7'd10, 5'd2, 11'h2DA, "direct_cell");
    read_cell(7'd0, 5'd1, 11'h0D1, "stream_after_wr");
    direct_wr(7'd5, 5'd31, 11'h7FF);
    direct_wr(7'd85, 5'd0, 11'h7FF);
    read_cell(7'd5, 5'd1, BLANK, "oor_write_ignored");

    send_char(7'h0C, 4'h0);
    measure_busy("ff_busy_cycles", 2400);
    check_cursor(0, 0, "ff_cursor");
    read_cell(7'd0, 5'd0, BLANK, "ff_blank");

    for (int i = 0; i < 81; i++) send_char(7'(8'h21 + i), 4'h0);
    check_cursor(1, 1, "wrap_cursor");
    read_cell(7'd0, 5'd1, 11'h071, "wrap_char81");
    read_cell(7'd79, 5'd0, 11'h070, "wrap_char80");

    for (int i = 0; i < 28; i++) send_char(7'h0A, 4'h0);
    for (int i = 0; i < 5; i++) send_char(7'h76, 4'h2);
    check_cursor(5, 29, "pre_scroll_cursor");
    send_char(7'h0A, 4'h0);
    measure_busy("scroll_busy_cycles", 80);
    check_cursor(0, 29, "scroll_cursor");
    read_cell(7'd0, 5'd0, 11'h071, "scroll_row0");
    read_cell(7'd0, 5'd28, 11'h176, "scroll_row28");
    read_cell(7'd0, 5'd29, BLANK, "scroll_row29");
    direct_wr(7'd3, 5'd29, 11'h155);
    read_cell(7'd3, 5'd29, 11'h155, "scroll_direct");

    rd_x = 7'd0; rd_y = 5'd29;
    send_char(7'h0C, 4'h0);
    repeat (100) tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 1);
    check_cursor(0, 0, "mid_rst_cursor");
    tick(); tick();
    reset = 1'b1;
    measure_busy("restart_busy_cycles", 2400);
    check("restart_in_ready", in_ready, 1);
    read_cell(7'd0, 5'd28, BLANK, "restart_blank");
    read_cell(7'd3, 5'd0, BLANK, "restart_blank2");

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_terminal_buffer.md
TEXT_TERMINAL_BUFFER -- requirements
Module: text_terminal_buffer

Interface
REQ-001 Parameter COLS, 80, character columns per row.
REQ-002 Parameter ROWS, 30, character rows per screen.
REQ-003 Parameter CHAR_W, 7, character code width in bits.
REQ-004 Parameter ATTR_W, 4, per-cell colour attribute width in bits.
REQ-005 Derived widths SHALL be XW = clog2(COLS) and YW = clog2(ROWS).
REQ-006 clk  input  1  system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  stream character offered.
REQ-009 in_ready  output  1  stream character accepted when in_valid && in_ready.
REQ-010 in_char  input  CHAR_W  stream character code (ASCII).
REQ-011 in_attr  input  ATTR_W  attribute stored with a printable stream character.
REQ-012 wr_en  input  1  direct cell write strobe.
REQ-013 wr_x / wr_y  input  XW / YW  direct write logical column / row.
REQ-014 wr_data  input  CHAR_W+ATTR_W  direct write cell value {attr, char}.
REQ-015 rd_x / rd_y  input  XW / YW  renderer read logical column / row.
REQ-016 rd_data  output  CHAR_W+ATTR_W  registered cell value {attr, char}.
REQ-017 cursor_x / cursor_y  output  XW / YW  current logical cursor position.
REQ-018 busy  output  1  high while any clear sequence runs.

Function
REQ-019 Blank cell SHALL be {attr 0, char 0x20}.
REQ-020 Printable stream char (0x20-0x7E) SHALL write {in_attr, in_char} at cursor and advance cursor_x by 1.
REQ-021 Advance from cursor_x = COLS-1 SHALL wrap to column 0 of the next row.
REQ-022 0x0A SHALL move cursor to column 0 of the next row; 0x0D to column 0 of same row; 0x08 decrements cursor_x, saturating at 0, no erase.
REQ-023 0x0C SHALL enter CLEAR_ALL: blank all COLS*ROWS cells at one cell per cycle, top_row := 0, cursor := (0,0).
REQ-024 All other codes SHALL be consumed with no effect.
REQ-025 Row advance from cursor_y = ROWS-1 SHALL scroll: top_row := (top_row+1) mod ROWS, cursor_y stays ROWS-1, then CLEAR_ROW blanks the newly exposed row over COLS cycles.
REQ-026 Logical row y SHALL map to physical row (top_row + y) mod ROWS for stream, direct write and read ports.
REQ-027 FSM states IDLE, CLEAR_ALL, CLEAR_ROW; return to IDLE the cycle after the last cell is cleared.
REQ-028 in_ready SHALL equal (state == IDLE) && !wr_en; busy SHALL equal (state != IDLE).
REQ-029 wr_en in IDLE SHALL write wr_data to (wr_x, wr_y) with priority over the stream; cursor unchanged.
REQ-030 wr_en during CLEAR_ALL/CLEAR_ROW, or with wr_x >= COLS or wr_y >= ROWS, SHALL be ignored.
REQ-031 rd_data SHALL reflect (rd_x, rd_y) sampled one cycle earlier; out-of-range coordinates return blank.
REQ-032 Read of a cell written in the same cycle SHALL return the old value (read-first).

Reset
REQ-033 Assertion SHALL asynchronously force cursor := (0,0), top_row := 0, rd_data := 0, in_ready := 0.
REQ-034 After deassertion the FSM SHALL enter CLEAR_ALL (busy = 1) and blank the whole buffer before in_ready rises.
REQ-035 Reset mid-clear or mid-scroll SHALL abort the sequence and restart from REQ-034.

Structure
REQ-036 Package text_term_pkg SHALL hold the FSM state type, control-code constants (0x08, 0x0A, 0x0C, 0x0D) and the blank-cell constant.
REQ-037 Storage SHALL be one sub-module text_char_ram: COLS*ROWS words, one write port, one registered read port.

Verification
REQ-038 Reset release -> busy high exactly 2400 cycles (80x30), then in_ready = 1; every rd_data = 0x020 (attr 0, space).
REQ-039 Stream "I AM" attr 0x3 -> cells (0..3,0) read {3,'I'},{3,' '},{3,'A'},{3,'M'}; cursor = (4,0).
REQ-040 81 printable chars from (0,0) -> char 81 at (0,1); cursor = (1,1).
REQ-041 Cursor (5,29), send 0x0A -> top_row = 1, busy for 80 cycles, logical row 29 blank, old logical row 1 now at row 0.
REQ-042 wr_en and in_valid same cycle in IDLE -> only direct write lands, in_ready = 0, stream char accepted next cycle.
REQ-043 0x0C mid-screen, then reset asserted at cycle 100 of clear -> outputs zeroed at once, full 2400-cycle clear restarts on release.
